// File: rtl/latch_mem_arb_pkg.sv
// Shared encodings and arbiter state type for the latch RAM front end.
// The request code is the 2-bit read_n/write_n field; 11 means no transaction.
package latch_mem_pkg;

    localparam logic [1:0] TXN_NONE = 2'b11;
    localparam logic [1:0] TXN_8    = 2'b00;
    localparam logic [1:0] TXN_16   = 2'b01;
    localparam logic [1:0] TXN_32   = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_t;

    // A master requests whenever either control field carries a transaction.
    function automatic logic is_req(input logic [1:0] rd_n, input logic [1:0] wr_n);
        return (rd_n & wr_n) != TXN_NONE;
    endfunction

endpackage

// File: rtl/latch_mem_arb.sv
// Two-master round-robin front end for the latch RAM: registered grant,
// combinational mem path, and a forced IDLE cycle after every transaction.
module latch_mem_arb
    import latch_mem_pkg::*;
#(
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [31:0]          a_wdata,
    input  logic [1:0]           a_write_n,
    input  logic [1:0]           a_read_n,
    output logic [31:0]          a_rdata,
    output logic                 a_ready,

    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [31:0]          b_wdata,
    input  logic [1:0]           b_write_n,
    input  logic [1:0]           b_read_n,
    output logic [31:0]          b_rdata,
    output logic                 b_ready,

    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [1:0]           mem_write_n,
    output logic [1:0]           mem_read_n,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready,

    output logic                 busy,
    output logic [1:0]           dbg_state
);

    // Handshake: a master holds its request (read_n/write_n != 11) until it
    // sees a one-cycle x_ready pulse, then drops it in the following cycle;
    // dropping it earlier aborts the grant without a ready.

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_last;
    logic       w_last_next;
    logic       w_a_req;
    logic       w_b_req;

    assign w_a_req = is_req(a_read_n, a_write_n);
    assign w_b_req = is_req(b_read_n, b_write_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_last  <= w_last_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_last_next = r_last;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_write_n = TXN_NONE;
        mem_read_n  = TXN_NONE;
        a_ready     = 1'b0;
        b_ready     = 1'b0;

        case (r_state)
            IDLE: begin
                // On a tie the port that was not served last wins.
                if (w_a_req && w_b_req) begin
                    w_next = r_last ? GNT_A : GNT_B;
                end else if (w_a_req) begin
                    w_next = GNT_A;
                end else if (w_b_req) begin
                    w_next = GNT_B;
                end
            end

            GNT_A: begin
                mem_addr    = a_addr;
                mem_wdata   = a_wdata;
                mem_write_n = a_write_n;
                mem_read_n  = a_read_n;
                a_ready     = mem_ready;
                if (!w_a_req) begin
                    w_next = IDLE;
                end else if (mem_ready) begin
                    w_next      = IDLE;
                    w_last_next = 1'b0;
                end
            end

            GNT_B: begin
                mem_addr    = b_addr;
                mem_wdata   = b_wdata;
                mem_write_n = b_write_n;
                mem_read_n  = b_read_n;
                b_ready     = mem_ready;
                if (!w_b_req) begin
                    w_next = IDLE;
                end else if (mem_ready) begin
                    w_next      = IDLE;
                    w_last_next = 1'b1;
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign a_rdata   = mem_rdata;
    assign b_rdata   = mem_rdata;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_latch_mem_arb.sv
// Bench for latch_mem_arb: a behavioural latch RAM stub on the mem side and a
// byte-array reference model predicting grant order, ready cycles and read data.
module tb_latch_mem_arb;
    import latch_mem_pkg::*;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] a_addr, b_addr, mem_addr;
    logic [31:0]   a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic [1:0]    a_write_n, a_read_n, b_write_n, b_read_n, mem_write_n, mem_read_n;
    logic [1:0]    dbg_state;
    logic          a_ready, b_ready, mem_ready, busy;

    int n_checks = 0;
    int n_errors = 0;

    latch_mem_arb #(.ADDR_BITS(AW)) dut (
        .clk(clk), .rst(rst),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_write_n(a_write_n), .a_read_n(a_read_n),
        .a_rdata(a_rdata), .a_ready(a_ready),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_write_n(b_write_n), .b_read_n(b_read_n),
        .b_rdata(b_rdata), .b_ready(b_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_n(mem_write_n),
        .mem_read_n(mem_read_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- latch RAM stub ----------------
    function automatic int nbytes(input logic [1:0] code);
        case (code)
            TXN_8:   return 1;
            TXN_16:  return 2;
            TXN_32:  return 4;
            default: return 0;
        endcase
    endfunction

    logic [7:0] ram [32];
    int         ram_cnt;
    bit         ram_clr = 1'b1;
    bit         force_rdy = 1'b0;
    logic [1:0] ram_code;
    logic [4:0] ma1, ma2, ma3;

    assign ram_code  = mem_write_n & mem_read_n;
    assign ma1       = mem_addr + 5'd1;
    assign ma2       = mem_addr + 5'd2;
    assign ma3       = mem_addr + 5'd3;
    assign mem_ready = force_rdy | ((ram_code != TXN_NONE) && (ram_cnt == nbytes(ram_code)));
    assign mem_rdata = {ram[ma3], ram[ma2], ram[ma1], ram[mem_addr]};

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 32; i++) ram[i] <= 8'h00;
            ram_cnt <= 0;
        end else if (ram_code == TXN_NONE) begin
            ram_cnt <= 0;
        end else begin
            ram_cnt <= ram_cnt + 1;
            if (mem_ready && !force_rdy && mem_write_n != TXN_NONE)
                for (int i = 0; i < nbytes(mem_write_n); i++)
                    ram[5'(int'(mem_addr) + i)] <= mem_wdata[8*i +: 8];
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [32];
    int          model_last;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] ref_read(input logic [4:0] addr, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = ref_mem[(int'(addr) + i) % 32];
        return r;
    endfunction

    function automatic logic [31:0] width_mask(input int n);
        return (n >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    endfunction

    task automatic ref_write(input logic [4:0] addr, input int n, input logic [31:0] data);
        for (int i = 0; i < n; i++) ref_mem[(int'(addr) + i) % 32] = data[8*i +: 8];
    endtask

    // ---------------- drivers ----------------
    task automatic drive_a(input logic [1:0] code, input bit wr, input logic [4:0] addr, input logic [31:0] data);
        a_addr = addr; a_wdata = data;
        a_write_n = wr ? code : TXN_NONE;
        a_read_n  = wr ? TXN_NONE : code;
    endtask

    task automatic drive_b(input logic [1:0] code, input bit wr, input logic [4:0] addr, input logic [31:0] data);
        b_addr = addr; b_wdata = data;
        b_write_n = wr ? code : TXN_NONE;
        b_read_n  = wr ? TXN_NONE : code;
    endtask

    int          rdy_cyc_a, rdy_cyc_b, pulses_a, pulses_b;
    logic [31:0] rd_a, rd_b;
    logic        log_busy [64];
    logic [1:0]  log_wn [64];
    logic [1:0]  log_rn [64];
    logic [4:0]  log_addr [64];

    // Starts at posedge+1 (cycle 0); each master drops its request the cycle
    // after its ready. Ready cycles stay -1 if the budget expires.
    task automatic run_txn(
        input bit en_a, input logic [1:0] code_a, input bit wr_a, input logic [4:0] addr_a,
        input logic [31:0] data_a, input int start_a, input int abort_a,
        input bit en_b, input logic [1:0] code_b, input bit wr_b, input logic [4:0] addr_b,
        input logic [31:0] data_b, input int start_b, input int n_cycles);
        bit drop_a, drop_b;
        drop_a = 1'b0; drop_b = 1'b0;
        rdy_cyc_a = -1; rdy_cyc_b = -1; pulses_a = 0; pulses_b = 0;
        rd_a = '0; rd_b = '0;
        for (int c = 0; c < n_cycles; c++) begin
            if (en_a && c == start_a) drive_a(code_a, wr_a, addr_a, data_a);
            if (en_a && c == abort_a) drive_a(TXN_NONE, 1'b0, '0, '0);
            if (en_b && c == start_b) drive_b(code_b, wr_b, addr_b, data_b);
            if (drop_a) begin drive_a(TXN_NONE, 1'b0, '0, '0); drop_a = 1'b0; end
            if (drop_b) begin drive_b(TXN_NONE, 1'b0, '0, '0); drop_b = 1'b0; end
            @(negedge clk);
            log_busy[c] = busy; log_wn[c] = mem_write_n; log_rn[c] = mem_read_n; log_addr[c] = mem_addr;
            if (a_ready) begin
                pulses_a++;
                if (rdy_cyc_a < 0) begin rdy_cyc_a = c; rd_a = a_rdata; end
                drop_a = 1'b1;
            end
            if (b_ready) begin
                pulses_b++;
                if (rdy_cyc_b < 0) begin rdy_cyc_b = c; rd_b = b_rdata; end
                drop_b = 1'b1;
            end
            @(posedge clk); #1;
        end
        drive_a(TXN_NONE, 1'b0, '0, '0);
        drive_b(TXN_NONE, 1'b0, '0, '0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive_a(TXN_NONE, 1'b0, '0, '0);
        drive_b(TXN_NONE, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_last = 1;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        drive_a(TXN_32, 1'b0, 5'h07, 32'hFFFF_FFFF);
        drive_b(TXN_8, 1'b1, 5'h11, 32'h5A5A_5A5A);
        @(posedge clk); @(negedge clk);
        n_checks++; if (mem_write_n !== TXN_NONE) begin n_errors++; $display("FAIL reset_mem_write_n got %b want 11", mem_write_n); end
        n_checks++; if (mem_read_n !== TXN_NONE) begin n_errors++; $display("FAIL reset_mem_read_n got %b want 11", mem_read_n); end
        n_checks++; if (mem_addr !== 5'h00) begin n_errors++; $display("FAIL reset_mem_addr got %h want 00", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready got a=%b b=%b want 0 0", a_ready, b_ready); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        drive_a(TXN_NONE, 1'b0, '0, '0);
        drive_b(TXN_NONE, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b0; ram_clr = 1'b0; model_last = 1;
        force_rdy = 1'b1;
        @(negedge clk);
        n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_errors++; $display("FAIL idle_ready_leak got a=%b b=%b want 0 0", a_ready, b_ready); end
        force_rdy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw;
        logic [31:0] exp;
        run_txn(1'b1, TXN_32, 1'b1, 5'h04, 32'hDEAD_BEEF, 0, -1, 1'b0, TXN_NONE, 1'b0, '0, '0, 0, 9);
        ref_write(5'h04, 4, 32'hDEAD_BEEF); model_last = 0;
        n_checks++; if (rdy_cyc_a != 5) begin n_errors++; $display("FAIL word_write_ready_cycle got %0d want 5", rdy_cyc_a); end
        n_checks++; if (pulses_a != 1) begin n_errors++; $display("FAIL word_write_pulses got %0d want 1", pulses_a); end
        n_checks++; if (log_addr[1] !== 5'h04 || log_wn[1] !== TXN_32) begin n_errors++; $display("FAIL word_write_mem_path got addr=%h wn=%b want 04 10", log_addr[1], log_wn[1]); end
        n_checks++; if (log_busy[6] !== 1'b0 || log_wn[6] !== TXN_NONE || log_rn[6] !== TXN_NONE) begin n_errors++; $display("FAIL word_write_idle_gap got busy=%b wn=%b rn=%b want 0 11 11", log_busy[6], log_wn[6], log_rn[6]); end
        run_txn(1'b1, TXN_32, 1'b0, 5'h04, 32'h0, 0, -1, 1'b0, TXN_NONE, 1'b0, '0, '0, 0, 9);
        exp = ref_read(5'h04, 4);
        n_checks++; if (rdy_cyc_a != 5) begin n_errors++; $display("FAIL word_read_ready_cycle got %0d want 5", rdy_cyc_a); end
        n_checks++; if (rd_a !== exp) begin n_errors++; $display("FAIL word_read_data got %h want %h", rd_a, exp); end
    endtask

    task automatic test_tie;
        logic [31:0] exp;
        do_reset;
        run_txn(1'b1, TXN_8, 1'b0, 5'h05, '0, 0, -1, 1'b1, TXN_8, 1'b0, 5'h07, '0, 0, 10);
        n_checks++; if (rdy_cyc_a != 2) begin n_errors++; $display("FAIL tie1_a_ready got %0d want 2", rdy_cyc_a); end
        n_checks++; if (rdy_cyc_b != 5) begin n_errors++; $display("FAIL tie1_b_ready got %0d want 5", rdy_cyc_b); end
        n_checks++; if (log_busy[3] !== 1'b0 || log_rn[3] !== TXN_NONE) begin n_errors++; $display("FAIL tie1_idle_gap got busy=%b rn=%b want 0 11", log_busy[3], log_rn[3]); end
        exp = ref_read(5'h05, 1);
        n_checks++; if ((rd_a & 32'hFF) !== exp) begin n_errors++; $display("FAIL tie1_a_data got %h want %h", rd_a & 32'hFF, exp); end
        exp = ref_read(5'h07, 1);
        n_checks++; if ((rd_b & 32'hFF) !== exp) begin n_errors++; $display("FAIL tie1_b_data got %h want %h", rd_b & 32'hFF, exp); end
        n_checks++; if (pulses_a != 1 || pulses_b != 1) begin n_errors++; $display("FAIL tie1_pulses got a=%0d b=%0d want 1 1", pulses_a, pulses_b); end
        // B was served last, so the next tie goes to A again.
        run_txn(1'b1, TXN_8, 1'b0, 5'h04, '0, 0, -1, 1'b1, TXN_16, 1'b0, 5'h10, '0, 0, 10);
        n_checks++; if (rdy_cyc_a != 2 || rdy_cyc_b != 6) begin n_errors++; $display("FAIL tie2_order got a=%0d b=%0d want 2 6", rdy_cyc_a, rdy_cyc_b); end
        run_txn(1'b1, TXN_8, 1'b0, 5'h06, '0, 0, -1, 1'b0, TXN_NONE, 1'b0, '0, '0, 0, 4);
        run_txn(1'b1, TXN_8, 1'b0, 5'h04, '0, 0, -1, 1'b1, TXN_8, 1'b0, 5'h05, '0, 0, 10);
        n_checks++; if (rdy_cyc_b != 2 || rdy_cyc_a != 5) begin n_errors++; $display("FAIL tie3_order got a=%0d b=%0d want 5 2", rdy_cyc_a, rdy_cyc_b); end
        model_last = 0;
    endtask

    task automatic test_contention;
        logic [31:0] exp;
        bit          ok;
        run_txn(1'b1, TXN_8, 1'b0, 5'h1E, '0, 1, -1, 1'b1, TXN_16, 1'b1, 5'h1E, 32'h0000_1234, 0, 10);
        ref_write(5'h1E, 2, 32'h0000_1234); model_last = 0;
        n_checks++; if (rdy_cyc_b != 3) begin n_errors++; $display("FAIL cont_b_ready got %0d want 3", rdy_cyc_b); end
        n_checks++; if (rdy_cyc_a != 6) begin n_errors++; $display("FAIL cont_a_ready got %0d want 6", rdy_cyc_a); end
        ok = 1'b1;
        for (int c = 1; c <= 3; c++) if (log_wn[c] !== TXN_16 || log_addr[c] !== 5'h1E) ok = 1'b0;
        n_checks++; if (!ok) begin n_errors++; $display("FAIL cont_b_holds_mem got wn=%b/%b/%b want 01 01 01", log_wn[1], log_wn[2], log_wn[3]); end
        n_checks++; if (log_busy[4] !== 1'b0 || log_wn[4] !== TXN_NONE || log_rn[4] !== TXN_NONE) begin n_errors++; $display("FAIL cont_idle_gap got busy=%b wn=%b rn=%b want 0 11 11", log_busy[4], log_wn[4], log_rn[4]); end
        exp = ref_read(5'h1E, 1);
        n_checks++; if ((rd_a & 32'hFF) !== exp || exp !== 32'h34) begin n_errors++; $display("FAIL cont_byte_1e got %h want 34", rd_a & 32'hFF); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp;
        run_txn(1'b1, TXN_8, 1'b1, 5'h00, 32'h0000_00A5, 0, -1, 1'b0, TXN_NONE, 1'b0, '0, '0, 0, 4);
        ref_write(5'h00, 1, 32'h0000_00A5);
        run_txn(1'b0, TXN_NONE, 1'b0, '0, '0, 0, -1, 1'b1, TXN_16, 1'b0, 5'h1F, '0, 0, 6);
        model_last = 1;
        exp = ref_read(5'h1F, 2);
        n_checks++; if (rdy_cyc_b != 3) begin n_errors++; $display("FAIL wrap_ready got %0d want 3", rdy_cyc_b); end
        n_checks++; if ((rd_b & 32'hFFFF) !== exp || exp !== 32'hA512) begin n_errors++; $display("FAIL wrap_data got %h want a512", rd_b & 32'hFFFF); end
    endtask

    task automatic test_abort;
        logic [31:0] exp;
        run_txn(1'b1, TXN_32, 1'b0, 5'h08, '0, 0, 2, 1'b0, TXN_NONE, 1'b0, '0, '0, 0, 7);
        n_checks++; if (pulses_a != 0) begin n_errors++; $display("FAIL abort_no_ready got %0d pulses want 0", pulses_a); end
        n_checks++; if (log_busy[3] !== 1'b0 || log_rn[3] !== TXN_NONE) begin n_errors++; $display("FAIL abort_idle got busy=%b rn=%b want 0 11", log_busy[3], log_rn[3]); end
        run_txn(1'b0, TXN_NONE, 1'b0, '0, '0, 0, -1, 1'b1, TXN_8, 1'b0, 5'h1E, '0, 0, 5);
        exp = ref_read(5'h1E, 1);
        n_checks++; if (rdy_cyc_b != 2 || (rd_b & 32'hFF) !== exp) begin n_errors++; $display("FAIL abort_follow_b got cyc=%0d data=%h want 2 %h", rdy_cyc_b, rd_b & 32'hFF, exp); end
        // The abort must not have moved the fairness pointer: B was last, so A wins a tie.
        run_txn(1'b1, TXN_8, 1'b0, 5'h02, '0, 0, -1, 1'b1, TXN_8, 1'b0, 5'h03, '0, 0, 9);
        n_checks++; if (rdy_cyc_a != 2 || rdy_cyc_b != 5) begin n_errors++; $display("FAIL abort_last_kept got a=%0d b=%0d want 2 5", rdy_cyc_a, rdy_cyc_b); end
        model_last = 1;
    endtask

    task automatic test_reset_mid;
        logic [31:0] exp;
        drive_a(TXN_32, 1'b0, 5'h04, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (mem_read_n !== TXN_NONE || a_ready !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL reset_mid got rn=%b ready=%b busy=%b want 11 0 0", mem_read_n, a_ready, busy); end
        drive_a(TXN_NONE, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b0; model_last = 1;
        run_txn(1'b1, TXN_8, 1'b0, 5'h05, '0, 0, -1, 1'b0, TXN_NONE, 1'b0, '0, '0, 0, 5);
        model_last = 0;
        exp = ref_read(5'h05, 1);
        n_checks++; if (rdy_cyc_a != 2 || (rd_a & 32'hFF) !== exp) begin n_errors++; $display("FAIL reset_mid_recover got cyc=%0d data=%h want 2 %h", rdy_cyc_a, rd_a & 32'hFF, exp); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            int          mode, na, nb, order[2], n_ord, exp_a, exp_b, n_sel;
            logic [1:0]  ca, cb;
            bit          wa, wb, en_a, en_b;
            logic [4:0]  aa, ab;
            logic [31:0] da, db, got, exp;
            mode = $urandom_range(0, 2);
            ca = 2'($urandom_range(0, 2)); cb = 2'($urandom_range(0, 2));
            wa = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
            aa = 5'($urandom_range(0, 31)); ab = 5'($urandom_range(0, 31));
            da = $urandom; db = $urandom;
            na = nbytes(ca); nb = nbytes(cb);
            en_a = (mode != 1); en_b = (mode != 0);
            exp_a = -1; exp_b = -1;
            if (mode == 0) begin order[0] = 0; n_ord = 1; exp_a = 1 + na; end
            else if (mode == 1) begin order[0] = 1; n_ord = 1; exp_b = 1 + nb; end
            else begin
                order[0] = (model_last == 1) ? 0 : 1; order[1] = 1 - order[0]; n_ord = 2;
                if (order[0] == 0) begin exp_a = 1 + na; exp_b = na + nb + 3; end
                else begin exp_b = 1 + nb; exp_a = na + nb + 3; end
            end
            for (int k = 0; k < n_ord; k++) begin
                if (order[k] == 0) begin
                    if (wa) ref_write(aa, na, da); else exp_q.push_back(ref_read(aa, na));
                end else begin
                    if (wb) ref_write(ab, nb, db); else exp_q.push_back(ref_read(ab, nb));
                end
                model_last = order[k];
            end
            run_txn(en_a, ca, wa, aa, da, 0, -1, en_b, cb, wb, ab, db, 0, 16);
            for (int k = 0; k < n_ord; k++) begin
                if (order[k] == 0) begin
                    n_checks++; if (rdy_cyc_a != exp_a || pulses_a != 1) begin n_errors++; $display("FAIL rand%0d_a_ready got cyc=%0d pulses=%0d want %0d 1", it, rdy_cyc_a, pulses_a, exp_a); end
                end else begin
                    n_checks++; if (rdy_cyc_b != exp_b || pulses_b != 1) begin n_errors++; $display("FAIL rand%0d_b_ready got cyc=%0d pulses=%0d want %0d 1", it, rdy_cyc_b, pulses_b, exp_b); end
                end
                if ((order[k] == 0 && !wa) || (order[k] == 1 && !wb)) begin
                    n_sel = (order[k] == 0) ? na : nb;
                    got = ((order[k] == 0) ? rd_a : rd_b) & width_mask(n_sel);
                    exp = exp_q.pop_front();
                    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL rand%0d_port%0d_rdata got %h want %h", it, order[k], got, exp); end
                end
            end
            if (!en_a) begin
                n_checks++; if (pulses_a != 0) begin n_errors++; $display("FAIL rand%0d_a_spurious got %0d pulses want 0", it, pulses_a); end
            end
            if (!en_b) begin
                n_checks++; if (pulses_b != 0) begin n_errors++; $display("FAIL rand%0d_b_spurious got %0d pulses want 0", it, pulses_b); end
            end
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        model_last = 1;
        rst = 1'b1;
        drive_a(TXN_NONE, 1'b0, '0, '0);
        drive_b(TXN_NONE, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_word_rw;
        test_tie;
        test_contention;
        test_wrap;
        test_abort;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the test sequence completed");
        $fatal(1, "watchdog");
    end

endmodule
